// File: rtl/axis_i2c_slave.sv
// I2C target: oversampled SCL/SDA decode, master writes out on m_axis, read bytes from s_axis.
// The target only ever pulls SDA low; SCL is never driven (no clock stretching).
module axis_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic       busy,
    output logic       overflow,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE, ADDR, IGNORE, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_s, sda_s, scl_d, sda_d;
    logic [1:0]             fall_pipe;
    logic                   scl_rise, scl_fall, start_c, stop_c;
    logic [3:0]             cnt, cnt_nxt;
    logic [7:0]             rx_sh, rx_next, tx_sh, tx_load;
    logic                   rw_q, ack_q, mack_q, sda_oe_nxt;
    logic                   addr_done, addr_hit, wr_done, ld_tx;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_sync  <= '1;
            sda_sync  <= '1;
            scl_d     <= 1'b1;
            sda_d     <= 1'b1;
            fall_pipe <= '0;
        end else begin
            scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d     <= scl_s;
            sda_d     <= sda_s;
            fall_pipe <= {fall_pipe[0], ~scl_s & scl_d};
        end
    end

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d;
    // Fall is acted on two clocks late so SDA changes well inside the low phase
    assign scl_fall = fall_pipe[1];
    assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;

    assign rx_next   = {rx_sh[6:0], sda_s};
    assign addr_done = (state == ADDR) && scl_rise && (cnt == 4'd7);
    assign addr_hit  = (rx_next[7:1] == SLAVE_ADDR);
    assign wr_done   = (state == WR_DATA) && scl_rise && (cnt == 4'd7);
    assign tx_load   = s_axis_tvalid ? s_axis_tdata : IDLE_BYTE;
    assign ld_tx     = scl_fall && (cnt == 4'd0) && !start_c && !stop_c &&
                       (((state == ADDR_ACK) && rw_q) || ((state == RD_ACK) && mack_q));

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (stop_c)       state_nxt = IDLE;
        else if (start_c) state_nxt = ADDR;
        else begin
            case (state)
                ADDR:     if (addr_done) state_nxt = addr_hit ? ADDR_ACK : IGNORE;
                ADDR_ACK: if (scl_fall && cnt == 4'd0) state_nxt = rw_q ? RD_DATA : WR_DATA;
                WR_DATA:  if (wr_done) state_nxt = WR_ACK;
                WR_ACK:   if (scl_fall && cnt == 4'd0) state_nxt = WR_DATA;
                RD_DATA:  if (scl_fall && cnt == 4'd8) state_nxt = RD_ACK;
                RD_ACK:   if (scl_fall && cnt == 4'd0) state_nxt = mack_q ? RD_DATA : IGNORE;
                default:  ;
            endcase
        end
    end

    // cnt==8 marks the low phase before the 9th pulse; it wraps to 0 on the 9th rise
    always_comb begin
        sda_oe_nxt = sda_oe;
        cnt_nxt    = cnt;
        if (start_c || stop_c) begin
            sda_oe_nxt = 1'b0;
            cnt_nxt    = 4'd0;
        end else begin
            case (state)
                ADDR, WR_DATA, RD_DATA: begin
                    if (scl_rise) cnt_nxt = cnt + 4'd1;
                    if (state == RD_DATA && scl_fall)
                        sda_oe_nxt = (cnt == 4'd8) ? 1'b0 : ~tx_sh[6];
                end
                ADDR_ACK, WR_ACK, RD_ACK: begin
                    if (scl_rise) cnt_nxt = 4'd0;
                    if (scl_fall && cnt == 4'd8)
                        sda_oe_nxt = (state == ADDR_ACK) ? 1'b1 : (state == WR_ACK) ? ack_q : 1'b0;
                    else if (scl_fall && cnt == 4'd0)
                        sda_oe_nxt = ld_tx ? ~tx_load[7] : 1'b0;
                end
                default: sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sda_oe        <= 1'b0;
            cnt           <= '0;
            rx_sh         <= '0;
            tx_sh         <= '0;
            rw_q          <= 1'b0;
            ack_q         <= 1'b0;
            mack_q        <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
            busy          <= 1'b0;
            overflow      <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            sda_oe        <= sda_oe_nxt;
            cnt           <= cnt_nxt;
            s_axis_tready <= ld_tx & s_axis_tvalid;
            underrun      <= ld_tx & ~s_axis_tvalid;
            overflow      <= wr_done & m_axis_tvalid;
            if (scl_rise) rx_sh <= rx_next;
            if (addr_done) rw_q <= rx_next[0];
            if (wr_done) ack_q <= ~m_axis_tvalid;
            if (state == RD_ACK && scl_rise) mack_q <= ~sda_s;
            if (ld_tx) tx_sh <= tx_load;
            else if (state == RD_DATA && scl_fall && cnt != 4'd8) tx_sh <= {tx_sh[6:0], 1'b0};
            // A held byte blocks the new one even if the sink drains it this cycle
            if (wr_done && !m_axis_tvalid) begin
                m_axis_tdata  <= rx_next;
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (stop_c) busy <= 1'b0;
            else if (addr_done && addr_hit) busy <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_i2c_slave.sv
// Directed bench for axis_i2c_slave: bit-banged I2C master on a wired-AND SDA line.
module tb_axis_i2c_slave;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_oe;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b0;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic       busy, overflow, underrun;
    logic       sda_bus;

    int passed = 0, total = 0;
    int rdy_cnt = 0, und_cnt = 0, ovf_cnt = 0;
    logic oe_seen = 1'b0;
    logic [7:0] mq[$];
    logic [7:0] txq[$];

    assign sda_bus = sda_m & ~sda_oe;

    axis_i2c_slave dut (
        .clk(clk), .arst_n(arst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .busy(busy), .overflow(overflow), .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_axis_tready) rdy_cnt++;
        if (underrun) und_cnt++;
        if (overflow) ovf_cnt++;
        if (sda_oe) oe_seen = 1'b1;
        if (m_axis_tvalid && m_axis_tready) mq.push_back(m_axis_tdata);
    end

    // s_axis source: pops its queue on each consume pulse
    always @(posedge clk) begin
        #1;
        if (s_axis_tready && txq.size() > 0) void'(txq.pop_front());
        s_axis_tvalid = (txq.size() > 0);
        s_axis_tdata  = (txq.size() > 0) ? txq[0] : 8'h00;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b0; tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(10);
        scl_m = 1'b1; tick(10);
        sda_m = 1'b1; tick(10);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(10);
            scl_m = 1'b1; tick(10);
            scl_m = 1'b0; tick(10);
        end
        sda_m = 1'b1; tick(10);
        scl_m = 1'b1; tick(10);
        ack = sda_oe;
        scl_m = 1'b0; tick(10);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sda_m = 1'b1; tick(10);
            scl_m = 1'b1; tick(10);
            d = {d[6:0], sda_bus};
            scl_m = 1'b0; tick(10);
        end
        sda_m = ~mack; tick(10);
        scl_m = 1'b1; tick(10);
        scl_m = 1'b0; tick(10);
    endtask

    task automatic test_reset();
        arst_n = 1'b0; tick(3);
        total++; if (sda_oe !== 1'b0) $display("FAIL reset_sda_oe got %b exp 0", sda_oe); else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid got %b exp 0", m_axis_tvalid); else passed++;
        total++; if (m_axis_tdata !== 8'h00) $display("FAIL reset_tdata got %h exp 00", m_axis_tdata); else passed++;
        total++; if ({s_axis_tready, busy, overflow, underrun} !== 4'b0)
            $display("FAIL reset_flags got %b exp 0000", {s_axis_tready, busy, overflow, underrun}); else passed++;
        arst_n = 1'b1; tick(5);
    endtask

    task automatic test_write();
        logic a0, a1, a2;
        m_axis_tready = 1'b1; mq.delete();
        i2c_start();
        write_byte(8'hA0, a0);
        total++; if (busy !== 1'b1) $display("FAIL wr_busy got %b exp 1", busy); else passed++;
        write_byte(8'hA5, a1);
        write_byte(8'h3C, a2);
        i2c_stop(); tick(5);
        total++; if ({a0, a1, a2} !== 3'b111) $display("FAIL wr_acks got %b exp 111", {a0, a1, a2}); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL wr_busy_after_stop got %b exp 0", busy); else passed++;
        total++; if (mq.size() != 2) $display("FAIL wr_count got %0d exp 2", mq.size());
        else if (mq[0] !== 8'hA5 || mq[1] !== 8'h3C) $display("FAIL wr_data got %h %h exp a5 3c", mq[0], mq[1]);
        else passed++;
    endtask

    task automatic test_wrong_addr();
        logic a0, a1;
        mq.delete(); tick(2); oe_seen = 1'b0;
        i2c_start();
        write_byte(8'hA2, a0);
        total++; if (busy !== 1'b0) $display("FAIL na_busy got %b exp 0", busy); else passed++;
        write_byte(8'h55, a1);
        i2c_stop(); tick(5);
        total++; if (oe_seen !== 1'b0) $display("FAIL na_oe_seen got %b exp 0", oe_seen); else passed++;
        total++; if (mq.size() != 0) $display("FAIL na_m_axis got %0d bytes exp 0", mq.size()); else passed++;
    endtask

    task automatic test_read();
        logic a; logic [7:0] d1, d2;
        txq.push_back(8'h96); txq.push_back(8'h5A); tick(2);
        rdy_cnt = 0; und_cnt = 0;
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(1'b1, d1);
        read_byte(1'b0, d2);
        tick(2); oe_seen = 1'b0;
        total++; if (a !== 1'b1) $display("FAIL rd_addr_ack got %b exp 1", a); else passed++;
        total++; if (d1 !== 8'h96) $display("FAIL rd_byte1 got %h exp 96", d1); else passed++;
        total++; if (d2 !== 8'h5A) $display("FAIL rd_byte2 got %h exp 5a", d2); else passed++;
        i2c_stop(); tick(5);
        total++; if (oe_seen !== 1'b0) $display("FAIL rd_release_after_nack got %b exp 0", oe_seen); else passed++;
        total++; if (rdy_cnt != 2 || und_cnt != 0)
            $display("FAIL rd_pulses got rdy=%0d und=%0d exp 2 0", rdy_cnt, und_cnt); else passed++;
    endtask

    task automatic test_underrun();
        logic a; logic [7:0] d;
        rdy_cnt = 0; und_cnt = 0;
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(1'b0, d);
        i2c_stop(); tick(5);
        total++; if (d !== 8'hFF) $display("FAIL ur_byte got %h exp ff", d); else passed++;
        total++; if (und_cnt != 1 || rdy_cnt != 0)
            $display("FAIL ur_pulses got und=%0d rdy=%0d exp 1 0", und_cnt, rdy_cnt); else passed++;
    endtask

    task automatic test_overflow();
        logic a0, a1, a2;
        m_axis_tready = 1'b0; mq.delete(); ovf_cnt = 0;
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h11, a1);
        write_byte(8'h22, a2);
        i2c_stop(); tick(5);
        total++; if ({a0, a1, a2} !== 3'b110) $display("FAIL ov_acks got %b exp 110", {a0, a1, a2}); else passed++;
        total++; if (ovf_cnt != 1) $display("FAIL ov_pulses got %0d exp 1", ovf_cnt); else passed++;
        total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11)
            $display("FAIL ov_held got v=%b d=%h exp 1 11", m_axis_tvalid, m_axis_tdata); else passed++;
        m_axis_tready = 1'b1; tick(4);
        total++; if (mq.size() != 1) $display("FAIL ov_drain_count got %0d exp 1", mq.size());
        else if (mq[0] !== 8'h11) $display("FAIL ov_drain_data got %h exp 11", mq[0]);
        else passed++;
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL ov_tvalid_clear got %b exp 0", m_axis_tvalid); else passed++;
    endtask

    task automatic test_rep_start();
        logic a0, a1, a2;
        m_axis_tready = 1'b1; mq.delete();
        txq.push_back(8'h3C); tick(2);
        i2c_start();
        write_byte(8'hA0, a0);
        write_byte(8'h01, a1);
        i2c_start();
        write_byte(8'hA1, a2);
        total++; if ({a0, a1, a2} !== 3'b111) $display("FAIL rs_acks got %b exp 111", {a0, a1, a2}); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL rs_busy got %b exp 1", busy); else passed++;
        total++; if (mq.size() != 1 || mq[0] !== 8'h01) $display("FAIL rs_wr_data got n=%0d exp one byte 01", mq.size()); else passed++;
        // bit 7 of 0x3C is 0, so the target is pulling SDA now
        total++; if (sda_oe !== 1'b1) $display("FAIL rs_read_drive got %b exp 1", sda_oe); else passed++;
        arst_n = 1'b0; #1;
        total++; if (sda_oe !== 1'b0) $display("FAIL arst_release got %b exp 0", sda_oe); else passed++;
        tick(2); arst_n = 1'b1; tick(3);
        total++; if (dut.state !== 3'd0 || busy !== 1'b0)
            $display("FAIL arst_idle got state=%0d busy=%b exp 0 0", dut.state, busy); else passed++;
        i2c_stop(); tick(5);
        total++; if (m_axis_tvalid !== 1'b0) $display("FAIL arst_tvalid got %b exp 0", m_axis_tvalid); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_wrong_addr();
        test_read();
        test_underrun();
        test_overflow();
        test_rep_start();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
